// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: packs big-endian bytes into 32-bit writes.
// Optional trailing checksum byte check enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int IMEM_WORDS = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] ADDR_LAST = 32'(IMEM_WORDS * 4 - 4);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHK, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        acc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic        err_q, err_d;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    acc = in_valid && in_ready;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d   = len;
          bidx_d  = '0;
          addr_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
          state_d = (len != 8'd0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        if (acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + in_data;
`endif
          bidx_d = bidx_q + 2'd1;
          asm_d  = {asm_q[15:0], in_data};
          // Fourth byte: the write is registered, so it lands while the next word streams in.
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = {asm_q, in_data};
            addr_d  = (addr_q == ADDR_LAST) ? 32'd0 : addr_q + 32'd4;
            cnt_d   = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (acc) begin
          err_d   = (in_data != sum_q);
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready = (state_q == S_LOAD) || (state_q == S_CHK);
  assign err      = err_q;
`else
  assign in_ready = (state_q == S_LOAD);
  assign err      = 1'b0;
`endif
  assign busy  = in_ready;
  assign done  = (state_q == S_DONE);
  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (default depth and depth 4) share one stimulus stream.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic        CLK, RST, start, in_valid;
  logic [7:0]  len, in_data;
  logic        in_ready_b, we_b, busy_b, done_b, err_b;
  logic [31:0] waddr_b, wdata_b;
  logic        in_ready_s, we_s, busy_s, done_s, err_s;
  logic [31:0] waddr_s, wdata_s;

  int checks = 0;
  int failures = 0;
  logic [63:0] wq_b[$];
  logic [63:0] wq_s[$];
  bit rdy_seen;

  imem_loader u_big (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  imem_loader #(.IMEM_WORDS(4)) u_small (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_s), .we(we_s), .waddr(waddr_s), .wdata(wdata_s),
    .busy(busy_s), .done(done_s), .err(err_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Write logger: records every write strobe observed just after the active edge.
  always @(posedge CLK) begin
    #1;
    if (we_b) wq_b.push_back({waddr_b, wdata_b});
    if (we_s) wq_s.push_back({waddr_s, wdata_s});
    if (in_ready_b || in_ready_s) rdy_seen = 1'b1;
  end

  // Stimulus driver; all input changes happen on the falling edge.
  // gap_mode: 0 back-to-back, 1 alternate valid 1/0, 2 random gaps.
  task automatic do_load(input int L, input bq_t bytes, input int gap_mode,
                         input int start_at, input int trailer, output bit ok);
    logic [7:0] s;
    int t;
    int gap;
    ok = 1'b1;
    s = 8'd0;
    start = 1'b1; len = 8'(L);
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < bytes.size(); i++) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((i == 0) ? 0 : 1) : int'($urandom_range(3, 0));
      repeat (gap) begin in_valid = 1'b0; @(negedge CLK); end
      in_valid = 1'b1; in_data = bytes[i];
      s = s + bytes[i];
      if (i == start_at) begin start = 1'b1; len = 8'd3; end
      t = 0;
      while (!in_ready_b && t < 50) begin @(negedge CLK); t++; end
      if (t >= 50) ok = 1'b0;
      @(negedge CLK);
      start = 1'b0;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    in_valid = 1'b1; in_data = (trailer < 0) ? s : 8'(trailer);
    t = 0;
    while (!in_ready_b && t < 50) begin @(negedge CLK); t++; end
    if (t >= 50) ok = 1'b0;
    @(negedge CLK);
`endif
    in_valid = 1'b0;
    t = 0;
    while (!done_b && t < 20) begin @(negedge CLK); t++; end
    if (t >= 20) ok = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({in_ready_b, we_b, busy_b, done_b, err_b} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b want=00000", {in_ready_b, we_b, busy_b, done_b, err_b});
    end
    checks++;
    if ({waddr_b, wdata_b} !== 64'd0 || {in_ready_s, we_s, busy_s, done_s} !== 4'b0) begin
      failures++; $display("FAIL reset_bus waddr=%h wdata=%h small=%b", waddr_b, wdata_b, {in_ready_s, we_s, busy_s, done_s});
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({in_ready_b, busy_b, done_b, we_b} !== 4'b0) begin
      failures++; $display("FAIL idle_after_reset got=%b want=0000", {in_ready_b, busy_b, done_b, we_b});
    end
  endtask

  task automatic test_len_zero;
    rdy_seen = 1'b0; wq_b.delete(); wq_s.delete();
    start = 1'b1; len = 8'd0;
    @(negedge CLK);
    start = 1'b0;
    checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0) begin
      failures++; $display("FAIL len0_done done=%b busy=%b want done=1 busy=0", done_b, busy_b);
    end
    repeat (4) @(negedge CLK);
    checks++;
    if (rdy_seen || wq_b.size() != 0 || wq_s.size() != 0) begin
      failures++; $display("FAIL len0_quiet rdy_seen=%b writes=%0d want 0 0", rdy_seen, wq_b.size());
    end
  endtask

  task automatic test_directed;
    bq_t b;
    bit ok;
    b = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    wq_b.delete(); wq_s.delete();
    do_load(2, b, 0, -1, -1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL dir_timeout ok=%b want=1", ok); end
    checks++;
    if (wq_b.size() != 2) begin
      failures++; $display("FAIL dir_count got=%0d want=2", wq_b.size());
    end else begin
      checks++;
      if (wq_b[0] !== {32'h0, 32'h00112233} || wq_b[1] !== {32'h4, 32'h44556677}) begin
        failures++; $display("FAIL dir_words got=%h %h want=0000000000112233 0000000444556677", wq_b[0], wq_b[1]);
      end
    end
    checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || err_b !== 1'b0) begin
      failures++; $display("FAIL dir_end done=%b busy=%b err=%b want 1 0 0", done_b, busy_b, err_b);
    end
  endtask

  task automatic test_checksum;
    bq_t b;
    bit ok;
    b = '{8'h01, 8'h02, 8'h03, 8'h04};
`ifdef IMEM_LOADER_CHECKSUM_EN
    do_load(1, b, 0, -1, 8'h0A, ok);
    checks++;
    if (!ok || err_b !== 1'b0) begin
      failures++; $display("FAIL chk_good err=%b ok=%b want err=0", err_b, ok);
    end
    do_load(1, b, 0, -1, 8'h0B, ok);
    checks++;
    if (!ok || err_b !== 1'b1) begin
      failures++; $display("FAIL chk_bad err=%b ok=%b want err=1", err_b, ok);
    end
`else
    do_load(1, b, 0, -1, -1, ok);
    rdy_seen = 1'b0;
    in_valid = 1'b1; in_data = 8'h0A;
    repeat (3) @(negedge CLK);
    in_valid = 1'b0;
    checks++;
    if (!ok || rdy_seen || err_b !== 1'b0 || done_b !== 1'b1) begin
      failures++; $display("FAIL no_trailer ok=%b rdy_seen=%b err=%b done=%b want 1 0 0 1", ok, rdy_seen, err_b, done_b);
    end
`endif
  endtask

  task automatic test_reset_mid_load;
    bq_t b;
    bit ok;
    start = 1'b1; len = 8'd1;
    @(negedge CLK);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hDE; @(negedge CLK);
    in_data = 8'hAD; @(negedge CLK);
    in_valid = 1'b0;
    wq_b.delete(); wq_s.delete();
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({in_ready_b, we_b, busy_b, done_b, err_b} !== 5'b0 || {waddr_b, wdata_b} !== 64'd0) begin
      failures++; $display("FAIL async_reset flags=%b waddr=%h wdata=%h want all 0",
                           {in_ready_b, we_b, busy_b, done_b, err_b}, waddr_b, wdata_b);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (wq_b.size() != 0 || busy_b !== 1'b0) begin
      failures++; $display("FAIL reset_no_write writes=%0d busy=%b want 0 0", wq_b.size(), busy_b);
    end
    b = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_load(1, b, 0, -1, -1, ok);
    checks++;
    if (!ok || wq_b.size() != 1 || wq_b[0] !== {32'h0, 32'h12345678}) begin
      failures++; $display("FAIL fresh_load ok=%b writes=%0d first=%h want 1 1 0000000012345678",
                           ok, wq_b.size(), (wq_b.size() > 0) ? wq_b[0] : 64'd0);
    end
  endtask

  task automatic test_wrap_ignored_start;
    bq_t b;
    bit ok;
    int nb;
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
    wq_b.delete(); wq_s.delete();
    do_load(5, b, 0, 8, -1, ok);
    nb = wq_s.size();
    checks++;
    if (!ok || nb != 5 || wq_b.size() != 5) begin
      failures++; $display("FAIL wrap_count ok=%b small=%0d big=%0d want 5 5", ok, nb, wq_b.size());
    end else begin
      for (int w = 0; w < 5; w++) begin
        checks++;
        if (wq_s[w] !== {32'((4 * w) % 16), b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]} ||
            wq_b[w] !== {32'(4 * w), b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]}) begin
          failures++; $display("FAIL wrap_word%0d small=%h big=%h", w, wq_s[w], wq_b[w]);
        end
      end
    end
  endtask

  task automatic test_valid_gaps;
    bq_t b;
    bit ok;
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    wq_b.delete(); wq_s.delete();
    do_load(1, b, 1, -1, -1, ok);
    checks++;
    if (!ok || wq_b.size() != 1 || wq_b[0] !== {32'h0, b[0], b[1], b[2], b[3]}) begin
      failures++; $display("FAIL gap_write ok=%b writes=%0d got=%h want=%h", ok, wq_b.size(),
                           (wq_b.size() > 0) ? wq_b[0] : 64'd0, {32'h0, b[0], b[1], b[2], b[3]});
    end
  endtask

  task automatic test_back_to_back;
    for (int it = 0; it < 6; it++) begin
      bq_t b;
      bit ok;
      int L;
      L = int'($urandom_range(10, 1));
      for (int i = 0; i < 4 * L; i++) b.push_back(8'($urandom));
      wq_b.delete(); wq_s.delete();
      do_load(L, b, (it % 2 == 0) ? 0 : 2, -1, -1, ok);
      checks++;
      if (!ok || wq_b.size() != L || wq_s.size() != L) begin
        failures++; $display("FAIL rand%0d_count ok=%b big=%0d small=%0d want %0d", it, ok, wq_b.size(), wq_s.size(), L);
      end else begin
        for (int w = 0; w < L; w++) begin
          checks++;
          if (wq_b[w] !== {32'(4 * w), b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]} ||
              wq_s[w] !== {32'((4 * w) % 16), b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]}) begin
            failures++; $display("FAIL rand%0d_word%0d big=%h small=%h", it, w, wq_b[w], wq_s[w]);
          end
        end
      end
      checks++;
      if (done_b !== 1'b1 || busy_b !== 1'b0 || err_b !== 1'b0 || in_ready_b !== 1'b0) begin
        failures++; $display("FAIL rand%0d_end done=%b busy=%b err=%b rdy=%b want 1 0 0 0", it, done_b, busy_b, err_b, in_ready_b);
      end
    end
  endtask

  initial begin
    test_reset;
    test_len_zero;
    test_directed;
    test_checksum;
    test_reset_mid_load;
    test_wrap_ignored_start;
    test_valid_gaps;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_WORDS, default 256, instruction-memory depth in 32-bit words.
REQ-002 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle load request; sampled only in IDLE or DONE.
REQ-005 len  input  8  number of 32-bit words to load, sampled with start.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data.
REQ-008 in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-009 we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 waddr  output  32  byte address of write, word-aligned (bits 1:0 = 0).
REQ-011 wdata  output  32  word to write.
REQ-012 busy  output  1  high in LOAD or CHK; drives CPU hold.
REQ-013 done  output  1  high in DONE.
REQ-014 err  output  1  checksum mismatch flag (see Configuration).

Function
REQ-015 FSM states IDLE, LOAD, CHK, DONE; IDLE->LOAD on start with len!=0; IDLE->DONE on start with len==0.
REQ-016 On start: word counter <= len, byte index <= 0, address <= 0, err <= 0.
REQ-017 in_ready SHALL equal 1 exactly in LOAD and CHK; no other backpressure.
REQ-018 Bytes assembled big-endian: byte 0 -> bits 31:24, byte 3 -> bits 7:0.
REQ-019 Cycle after 4th byte accepted: we=1 for exactly one cycle, waddr=current address, wdata=assembled word.
REQ-020 Address increments by 4 after each write, wrapping modulo IMEM_WORDS*4.
REQ-021 Back-to-back bytes every cycle SHALL be accepted without loss; a write may coincide with next-word byte acceptance.
REQ-022 After the write of word len: LOAD->CHK if checksum compiled in, else LOAD->DONE; in_ready drops the cycle the last byte is accepted.
REQ-023 CHK: accept one byte, set err if it differs from the 8-bit sum (mod 256) of all data bytes, then ->DONE.
REQ-024 DONE holds done=1 until start; start in DONE behaves as in IDLE.
REQ-025 start while busy SHALL be ignored.
REQ-026 in_valid gaps stall assembly only; partial word retained indefinitely.
REQ-027 we=0 whenever not issuing a write; wdata/waddr hold last values.

Reset
REQ-028 RST asserted, any state: state<=IDLE, in_ready, we, busy, done, err <= 0, waddr, wdata <= 0 immediately.
REQ-029 Reset mid-load SHALL discard the partial word and issue no further write.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN defined: CHK state, checksum accumulator and err logic present.
REQ-031 Macro undefined: no CHK state, no trailing byte consumed, err tied to 0.

Verification
REQ-032 len=2, bytes 00 11 22 33 44 55 66 77 every cycle -> we pulses: (0x0,0x00112233), (0x4,0x44556677); done=1; busy low after.
REQ-033 len=0 start -> DONE next cycle, no we, in_ready never 1.
REQ-034 CHECKSUM_EN, len=1, bytes 01 02 03 04 then 0A -> err=0; repeat with 0B -> err=1.
REQ-035 len=1, RST pulsed after 2 bytes -> all outputs 0 asynchronously, no we; fresh load then writes address 0x0.
REQ-036 IMEM_WORDS=4, len=5 -> fifth write at waddr 0x0; start pulsed mid-load ignored.
REQ-037 in_valid toggled 1/0 each cycle, len=1 -> single correct write after 4 accepted bytes.
